// File: rtl/hazard_byp_unit.sv
// ID-stage hazard and bypass controller: tracks in-flight writers, drives registered EX-stage
// bypass selects, and detects load-use hazards to stall/bubble the pipe.
module hazard_byp_unit #(
  parameter int unsigned RA_W  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  p0_addr,
  input  logic [RA_W-1:0]  p1_addr,
  input  logic             re0,
  input  logic             re1,
  input  logic [RA_W-1:0]  dst_addr_ID,
  input  logic             we_rf_ID,
  input  logic             ld_ID,
  input  logic             flush,
  input  logic             dm_stall,
  output logic             byp0_EX,
  output logic             byp1_EX,
  output logic             byp0_DM,
  output logic             byp1_DM,
  output logic             stall_IF_ID,
  output logic             stall_ID_EX,
  output logic             stall_EX_DM,
  output logic             stall_DM_WB,
  output logic             bubble_ID_EX,
  output logic [CNT_W-1:0] lu_stall_cnt
);

  // Writer tracking. The DM_WB stage needs no tracking here: the RF is write-before-read,
  // so a writer in WB never produces a bypass towards the reader in ID.
  logic [RA_W-1:0]  dst_id_ex_q, dst_id_ex_d;
  logic             we_id_ex_q, we_id_ex_d;
  logic             ld_id_ex_q, ld_id_ex_d;
  logic [RA_W-1:0]  dst_ex_dm_q, dst_ex_dm_d;
  logic             we_ex_dm_q, we_ex_dm_d;

  logic             byp0_ex_q, byp0_ex_d;
  logic             byp1_ex_q, byp1_ex_d;
  logic             byp0_dm_q, byp0_dm_d;
  logic             byp1_dm_q, byp1_dm_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             m0_id_ex, m1_id_ex;
  logic             m0_ex_dm, m1_ex_dm;
  logic             lu;
  logic             cnt_sat;

  function automatic logic src_match(input logic            we,
                                     input logic [RA_W-1:0] dst,
                                     input logic [RA_W-1:0] src,
                                     input logic            re);
    return we & re & (src != '0) & (dst == src);
  endfunction

  always_comb begin
    m0_id_ex = src_match(we_id_ex_q, dst_id_ex_q, p0_addr, re0);
    m1_id_ex = src_match(we_id_ex_q, dst_id_ex_q, p1_addr, re1);
    m0_ex_dm = src_match(we_ex_dm_q, dst_ex_dm_q, p0_addr, re0);
    m1_ex_dm = src_match(we_ex_dm_q, dst_ex_dm_q, p1_addr, re1);
    lu       = ld_id_ex_q & we_id_ex_q & (m0_id_ex | m1_id_ex);
    cnt_sat  = &cnt_q;
  end

  // Pipe control; flush wins over load-use since the instr in ID is being killed anyway.
  always_comb begin
    stall_IF_ID  = 1'b0;
    stall_ID_EX  = 1'b0;
    stall_EX_DM  = 1'b0;
    stall_DM_WB  = 1'b0;
    bubble_ID_EX = 1'b0;
    if (dm_stall) begin
      stall_IF_ID = 1'b1;
      stall_ID_EX = 1'b1;
      stall_EX_DM = 1'b1;
      stall_DM_WB = 1'b1;
    end else if (flush) begin
      bubble_ID_EX = 1'b1;
    end else if (lu) begin
      stall_IF_ID  = 1'b1;
      bubble_ID_EX = 1'b1;
    end
  end

  always_comb begin
    dst_id_ex_d = dst_id_ex_q;
    we_id_ex_d  = we_id_ex_q;
    ld_id_ex_d  = ld_id_ex_q;
    dst_ex_dm_d = dst_ex_dm_q;
    we_ex_dm_d  = we_ex_dm_q;
    byp0_ex_d   = byp0_ex_q;
    byp1_ex_d   = byp1_ex_q;
    byp0_dm_d   = byp0_dm_q;
    byp1_dm_d   = byp1_dm_q;
    cnt_d       = cnt_q;

    if (!dm_stall) begin
      dst_ex_dm_d = dst_id_ex_q;
      we_ex_dm_d  = we_id_ex_q;
      if (flush || lu) begin
        // Bubble enters EX: it writes nothing and reads nothing.
        dst_id_ex_d = dst_addr_ID;
        we_id_ex_d  = 1'b0;
        ld_id_ex_d  = 1'b0;
        byp0_ex_d   = 1'b0;
        byp1_ex_d   = 1'b0;
        byp0_dm_d   = 1'b0;
        byp1_dm_d   = 1'b0;
      end else begin
        dst_id_ex_d = dst_addr_ID;
        we_id_ex_d  = we_rf_ID;
        ld_id_ex_d  = ld_ID;
        byp0_ex_d   = m0_id_ex;
        byp1_ex_d   = m1_id_ex;
        byp0_dm_d   = m0_ex_dm & ~m0_id_ex;
        byp1_dm_d   = m1_ex_dm & ~m1_id_ex;
      end
      if (lu && !flush && !cnt_sat) begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dst_id_ex_q <= '0;
      we_id_ex_q  <= 1'b0;
      ld_id_ex_q  <= 1'b0;
      dst_ex_dm_q <= '0;
      we_ex_dm_q  <= 1'b0;
      byp0_ex_q   <= 1'b0;
      byp1_ex_q   <= 1'b0;
      byp0_dm_q   <= 1'b0;
      byp1_dm_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      dst_id_ex_q <= dst_id_ex_d;
      we_id_ex_q  <= we_id_ex_d;
      ld_id_ex_q  <= ld_id_ex_d;
      dst_ex_dm_q <= dst_ex_dm_d;
      we_ex_dm_q  <= we_ex_dm_d;
      byp0_ex_q   <= byp0_ex_d;
      byp1_ex_q   <= byp1_ex_d;
      byp0_dm_q   <= byp0_dm_d;
      byp1_dm_q   <= byp1_dm_d;
      cnt_q       <= cnt_d;
    end
  end

  assign byp0_EX      = byp0_ex_q;
  assign byp1_EX      = byp1_ex_q;
  assign byp0_DM      = byp0_dm_q;
  assign byp1_DM      = byp1_dm_q;
  assign lu_stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_byp_unit.sv
// Bench for hazard_byp_unit: directed pipeline sequences plus random traffic, checked
// against an instruction-level pipeline model through an expected-response queue.
module tb_hazard_byp_unit;
  localparam int unsigned RA_W  = 4;
  localparam int unsigned CNT_W = 4;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [RA_W-1:0]  p0_addr, p1_addr, dst_addr_ID;
  logic             re0, re1, we_rf_ID, ld_ID, flush, dm_stall;
  logic             byp0_EX, byp1_EX, byp0_DM, byp1_DM;
  logic             stall_IF_ID, stall_ID_EX, stall_EX_DM, stall_DM_WB, bubble_ID_EX;
  logic [CNT_W-1:0] lu_stall_cnt;

  hazard_byp_unit #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .p0_addr(p0_addr), .p1_addr(p1_addr), .re0(re0), .re1(re1),
    .dst_addr_ID(dst_addr_ID), .we_rf_ID(we_rf_ID), .ld_ID(ld_ID), .flush(flush),
    .dm_stall(dm_stall), .byp0_EX(byp0_EX), .byp1_EX(byp1_EX), .byp0_DM(byp0_DM),
    .byp1_DM(byp1_DM), .stall_IF_ID(stall_IF_ID), .stall_ID_EX(stall_ID_EX),
    .stall_EX_DM(stall_EX_DM), .stall_DM_WB(stall_DM_WB), .bubble_ID_EX(bubble_ID_EX),
    .lu_stall_cnt(lu_stall_cnt)
  );

  typedef struct packed {logic [RA_W-1:0] dst; logic we; logic ld;} instr_t;
  // byp = {byp0_EX, byp1_EX, byp0_DM, byp1_DM}
  // ctl = {stall_IF_ID, stall_ID_EX, stall_EX_DM, stall_DM_WB, bubble_ID_EX}
  typedef struct packed {logic [3:0] byp; logic [4:0] ctl; logic [CNT_W-1:0] cnt;} exp_t;

  exp_t   sb[$];
  instr_t in_ex, in_dm;   // instrs currently in EX and DM
  logic [3:0] m_byp;
  int     m_cnt;
  int     n_checks = 0;
  int     n_pass   = 0;

  function automatic bit reads(instr_t w, logic [RA_W-1:0] a, logic re);
    return w.we && re && (a != '0) && (w.dst == a);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk("byp", {28'd0, byp0_EX, byp1_EX, byp0_DM, byp1_DM}, {28'd0, e.byp});
      chk("ctl", {27'd0, stall_IF_ID, stall_ID_EX, stall_EX_DM, stall_DM_WB, bubble_ID_EX},
          {27'd0, e.ctl});
      chk("lu_cnt", {{(32-CNT_W){1'b0}}, lu_stall_cnt}, {{(32-CNT_W){1'b0}}, e.cnt});
    end
  end

  // One ID-stage cycle: drive, predict outputs for this cycle, advance model past the edge.
  task automatic step(input logic [RA_W-1:0] a0, input logic [RA_W-1:0] a1,
                      input logic r0, input logic r1, input logic [RA_W-1:0] d,
                      input logic w, input logic l, input logic fl, input logic ds,
                      input logic rs);
    exp_t   e;
    instr_t nxt;
    bit     lu, h0ex, h1ex;
    @(posedge clk);
    #1;
    p0_addr = a0; p1_addr = a1; re0 = r0; re1 = r1;
    dst_addr_ID = d; we_rf_ID = w; ld_ID = l; flush = fl; dm_stall = ds; rst = rs;

    lu = in_ex.ld && (reads(in_ex, a0, r0) || reads(in_ex, a1, r1));
    e.byp = m_byp;
    e.cnt = CNT_W'(m_cnt);
    if (ds)      e.ctl = 5'b11110;
    else if (fl) e.ctl = 5'b00001;
    else if (lu) e.ctl = 5'b10001;
    else         e.ctl = 5'b00000;
    sb.push_back(e);

    if (rs) begin
      in_ex = '0; in_dm = '0; m_byp = '0; m_cnt = 0;
    end else if (!ds) begin
      h0ex = reads(in_ex, a0, r0);
      h1ex = reads(in_ex, a1, r1);
      if (lu && !fl && m_cnt < CNT_MAX) m_cnt++;
      if (fl || lu) begin
        nxt   = '0;
        m_byp = '0;
      end else begin
        nxt.dst = d; nxt.we = w; nxt.ld = l;
        m_byp = {h0ex, h1ex, reads(in_dm, a0, r0) && !h0ex, reads(in_dm, a1, r1) && !h1ex};
      end
      in_dm = in_ex;
      in_ex = nxt;
    end
  endtask

  task automatic nop();
    step(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1; p0_addr = '0; p1_addr = '0; re0 = 1'b0; re1 = 1'b0;
    dst_addr_ID = '0; we_rf_ID = 1'b0; ld_ID = 1'b0; flush = 1'b0; dm_stall = 1'b0;
    in_ex = '0; in_dm = '0; m_byp = '0; m_cnt = 0;
    repeat (2) @(posedge clk);
    step(4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    nop();

    // Back-to-back ADD R3; ADD R4,R3,R3
    step(4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd3, 4'd3, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nop(); nop();
    // ADD R3; NOP; SUB R5,R3,R1
    step(4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nop();
    step(4'd3, 4'd1, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nop(); nop();
    // LW R2; ADD R6,R2,R1 (held in ID for the stall cycle)
    step(4'd1, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (2) step(4'd2, 4'd1, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nop(); nop();
    // R0 writer/reader, and re0=0 with address match
    step(4'd1, 4'd1, 1'b1, 1'b1, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'd0, 4'd0, 1'b1, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(4'd1, 4'd1, 1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'd5, 4'd1, 1'b0, 1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nop(); nop();
    // dm_stall held 3 cycles during back-to-back dependency
    step(4'd1, 4'd2, 1'b1, 1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step(4'd3, 4'd3, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    step(4'd3, 4'd3, 1'b1, 1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nop(); nop();
    // flush coincident with load-use
    step(4'd1, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'd2, 4'd1, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    nop(); nop();
    // Drive the counter into saturation and beyond
    for (int i = 0; i < CNT_MAX + 4; i++) begin
      step(4'd1, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) step(4'd3, 4'd2, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    // Reset while a load-use stall is pending under dm_stall
    step(4'd1, 4'd0, 1'b1, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(4'd2, 4'd1, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(4'd2, 4'd1, 1'b1, 1'b1, 4'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    nop();

    // Random traffic on a small register window to provoke many matches
    for (int i = 0; i < 3000; i++) begin
      step(RA_W'($urandom_range(0, 3)), RA_W'($urandom_range(0, 3)),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
           RA_W'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 99) == 0));
    end
    nop();

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
